// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage: ALU op codes, RV32I opcodes,
// flag bundle and result-buffer entry.
package alu_issue_pkg;

  localparam int DATA_W = 32;

  // op[3:1] selects the operation, op[0] is the sub/arithmetic-shift modifier
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h4;
  localparam logic [3:0] ALU_SLTU = 4'h6;
  localparam logic [3:0] ALU_XOR  = 4'h8;
  localparam logic [3:0] ALU_SRL  = 4'hA;
  localparam logic [3:0] ALU_SRA  = 4'hB;
  localparam logic [3:0] ALU_OR   = 4'hC;
  localparam logic [3:0] ALU_AND  = 4'hE;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic negative;
  } alu_signal;

  typedef struct packed {
    logic [4:0]        rd;
    logic              illegal;
    logic [DATA_W-1:0] result;
    alu_signal         flags;
  } issue_entry_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op[3:1] == 3'd1) || (op[3:1] == 3'd5);
  endfunction

endpackage

// File: rtl/alu_issue_result_fifo.sv
// In-order result buffer for the ALU issue stage. When empty, the head outputs
// keep showing the most recently popped entry.
module result_fifo
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  issue_entry_t     push_data,
  input  logic             pop,
  output logic             head_valid,
  output issue_entry_t     head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  issue_entry_t     mem [DEPTH];
  issue_entry_t     last;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  assign head_data  = head_valid ? mem[rd_ptr] : last;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
        last   <= mem[rd_ptr];
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of the 1-cycle registered ALU: decodes RV32I OP/OP-IMM/LUI/AUIPC,
// tracks the in-flight op and buffers results in order. Optional: ALU_ISSUE_RD0_DROP_EN.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN  = DATA_W,
  parameter int DEPTH = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  alu_signal       alu_flags,
  input  logic            alu_valid,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output alu_signal       out_flags,
  output logic            out_illegal
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] b_raw;
  logic            illegal;
  logic            fire;
  logic            unused_rs1_field;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign imm_i  = XLEN'($signed(in_instr[31:20]));
  assign imm_u  = XLEN'($signed({in_instr[31:12], 12'h000}));
  // register indices arrive already resolved into in_rs1/in_rs2
  assign unused_rs1_field = ^in_instr[19:15];

  always_comb begin
    alu_a   = '0;
    b_raw   = '0;
    alu_op  = ALU_ADD;
    illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          illegal = 1'b0;
          alu_a   = in_rs1;
          b_raw   = in_rs2;
          alu_op  = {f3, f7[5]};
        end
      end
      OPC_OPIMM: begin
        case (f3)
          3'b001:  illegal = (f7 != 7'h00);
          3'b101:  illegal = !(f7 == 7'h00 || f7 == 7'h20);
          default: illegal = 1'b0;
        endcase
        if (!illegal) begin
          alu_a  = in_rs1;
          b_raw  = imm_i;
          alu_op = (f3 == 3'b101) ? {f3, in_instr[30]} : {f3, 1'b0};
        end
      end
      OPC_LUI: begin
        illegal = 1'b0;
        b_raw   = imm_u;
      end
      OPC_AUIPC: begin
        illegal = 1'b0;
        alu_a   = in_pc;
        b_raw   = imm_u;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign alu_b = is_shift(alu_op) ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;

  logic       tag_valid;
  logic [4:0] tag_rd;
  logic       tag_illegal;

  assign fire = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid   <= 1'b0;
      tag_rd      <= '0;
      tag_illegal <= 1'b0;
    end else begin
      tag_valid <= fire;
      if (fire) begin
        tag_rd      <= illegal ? 5'd0 : in_instr[11:7];
        tag_illegal <= illegal;
      end
    end
  end

  issue_entry_t     push_data;
  issue_entry_t     head;
  logic             push;
  logic             push_illegal;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credits;

  // a tagged slot with no ALU valid means the op was lost; keep its slot but poison it
  assign push_illegal = tag_illegal || !alu_valid;

`ifdef ALU_ISSUE_RD0_DROP_EN
  assign push = tag_valid && !(!push_illegal && tag_rd == 5'd0);
`else
  assign push = tag_valid;
`endif

  always_comb begin
    push_data         = '0;
    push_data.rd      = tag_rd;
    push_data.illegal = push_illegal;
    push_data.result  = DATA_W'(alu_result);
    push_data.flags   = alu_flags;
  end

  result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (out_ready),
    .head_valid (out_valid),
    .head_data  (head),
    .count      (count)
  );

  assign credits  = {1'b0, count} + {{CNT_W{1'b0}}, tag_valid};
  assign in_ready = credits < (CNT_W+1)'(DEPTH);

  assign out_rd      = head.rd;
  assign out_illegal = head.illegal;
  assign out_result  = XLEN'(head.result);
  assign out_flags   = head.flags;

endmodule
